// File: rtl/serial_framer.sv
// Parallel-to-serial framer: start bit (1), data MSB-first, optional even parity, stop bit (0).
// Idle line is 0 so a downstream delay line that resets to 0 sees a quiet line.
module serial_framer #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_shreg;
    logic             r_par;
    logic             r_sout;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic             w_par_nxt;
    logic             w_sout_nxt;

    logic             w_bit_end;
    logic             w_last_stop;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_step;
    logic [WIDTH-1:0] w_shifted;

    assign w_bit_end   = (r_cnt == BIT_LAST);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end;
    assign w_cnt_step  = w_bit_end ? '0 : r_cnt + CNT_W'(1);
    assign w_shifted   = r_shreg << 1;

    // Ready is decoded from registered state only, never from valid_in.
    assign ready_out = (r_state == S_IDLE) || w_last_stop;
    assign w_accept  = valid_in && ready_out;
    assign busy      = (r_state != S_IDLE);
    assign done      = w_last_stop;
    assign sout      = r_sout;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_par   <= 1'b0;
            r_sout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shreg <= w_shreg_nxt;
            r_par   <= w_par_nxt;
            r_sout  <= w_sout_nxt;
        end
    end

    // sout is computed for the state being entered so it lines up with that state's cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shreg_nxt = r_shreg;
        w_par_nxt   = r_par;
        w_sout_nxt  = r_sout;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shreg_nxt = data_in;
                    w_par_nxt   = ^data_in;
                    w_sout_nxt  = 1'b1;
                end
            end
            S_START: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = '0;
                    w_sout_nxt  = r_shreg[WIDTH-1];
                end
            end
            S_DATA: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_end) begin
                    w_shreg_nxt = w_shifted;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt = '0;
                        if (PARITY_EN != 0) begin
                            w_state_nxt = S_PARITY;
                            w_sout_nxt  = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_sout_nxt  = 1'b0;
                        end
                    end else begin
                        w_idx_nxt  = r_idx + IDX_W'(1);
                        w_sout_nxt = w_shifted[WIDTH-1];
                    end
                end
            end
            S_PARITY: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_sout_nxt  = 1'b0;
                end
            end
            S_STOP: begin
                w_cnt_nxt = w_cnt_step;
                if (w_bit_end) begin
                    if (w_accept) begin
                        w_state_nxt = S_START;
                        w_shreg_nxt = data_in;
                        w_par_nxt   = ^data_in;
                        w_sout_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_sout_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_sout_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/serial_framer.md
# serial_framer

Parallel-to-serial framer that accepts a WIDTH-bit word over a valid/ready handshake and emits it as a framed bit stream on a single serial output. It sits directly upstream of the 4-stage `shiftreg` delay line and drives that block's `d` input, sharing its `clk` and `rstn`. A frame is one start bit, then the data bits MSB-first, then an optional even-parity bit, then one stop bit. Each bit is held for CLKS_PER_BIT cycles.

## Interface
- WIDTH, 8: data word width, 1..32.
- CLKS_PER_BIT, 1: cycles each serial bit is held, 1..255.
- PARITY_EN, 1: 1 = append even-parity bit; 0 = no parity bit.

- clk  input  1  single clock, all state updates on rising edge.
- rstn  input  1  reset, synchronous, active-low (sampled on rising edge of clk).
- data_in  input  WIDTH  word to transmit, sampled on handshake.
- valid_in  input  1  data_in valid.
- ready_out  output  1  framer can accept a word this cycle.
- sout  output  1  serial bit stream, connects to shiftreg `d`.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse in the final cycle of a frame's stop bit.

## Operation
- Handshake: a word is accepted on a rising edge where valid_in=1 and ready_out=1. data_in is captured into an internal shift register. data_in and valid_in are ignored at all other edges.
- Line levels: idle = 0, start bit = 1, stop bit = 0. Idle is 0 so that the downstream shiftreg, which resets to 0, sees a quiet line.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (PARITY_EN=1) or -> STOP (PARITY_EN=0) after WIDTH bits.
  - PARITY -> STOP after CLKS_PER_BIT cycles.
  - STOP -> START if a word is accepted in the last STOP cycle; otherwise STOP -> IDLE.
- Counters:
  - bit-time counter: 8 bits, counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - bit index counter: ceil(log2(WIDTH+1)) bits, counts data bits 0..WIDTH-1.
- Data order: MSB-first. Bit i of the DATA state drives data_in[WIDTH-1-i] as captured.
- Parity: XOR of all WIDTH captured bits. This makes the total count of 1s across data and parity even.
- ready_out is 1 in IDLE and in the last cycle of STOP, and 0 otherwise. It is decoded combinationally from registered state only; there is no path from valid_in to ready_out.
- busy is 1 in every state except IDLE.
- done is 1 only in the last cycle of STOP, including when a back-to-back accept happens in that same cycle.
- sout is a registered output: its value for state S is visible during the cycles that S occupies.

## Timing
- Reset (rstn=0 at an edge), from the following cycle: state=IDLE, sout=0, ready_out=1, busy=0, done=0, counters=0, data register=0.
- Reset mid-frame: the frame is aborted with no done pulse. sout returns to 0 in the next cycle and the captured word is discarded.
- rstn=0 at the same edge as a handshake: reset wins and the word is not accepted.
- Accept at edge 0: START occupies cycles 1..C, where C=CLKS_PER_BIT.
- Frame length F = (2 + WIDTH + PARITY_EN) x CLKS_PER_BIT cycles.
- done is in cycle F. busy is 1 during cycles 1..F.
- Back-to-back: a second accept at edge F gives a START in cycle F+1 with no idle gap. Sustained throughput is one word per F cycles.
- Downstream: a bit on sout appears at shiftreg `q` 4 cycles later.

## Test plan
- Reset: hold rstn=0 for 3 edges with valid_in=1 and data_in=0xFF -> sout=0, ready_out=1, busy=0, done=0 throughout; no frame starts after release until a new handshake.
- Single frame, WIDTH=8, C=1, PARITY_EN=1, data_in=0xA5 accepted at edge 0 -> sout in cycles 1..11 = 1,1,0,1,0,0,1,0,1,0,0; done=1 only in cycle 11; ready_out=0 in cycles 1..10.
- Odd-parity data with C=3, PARITY_EN=1, data_in=0x01 -> 33-cycle frame; parity bit=1 in cycles 28..30; stop bit=0 in cycles 31..33; done in cycle 33.
- Back-to-back 0x80 then 0x7F with valid_in held high, C=1, PARITY_EN=0 -> 20 continuous cycles: 1,1,0,0,0,0,0,0,0,0, then 1,0,1,1,1,1,1,1,1,0; two done pulses, in cycles 10 and 20.
- Reset mid-frame: assert rstn=0 in cycle 5 of the 0xA5 frame -> sout=0 from cycle 6; no done; the next handshake starts a clean frame.
- Chained with shiftreg: frame 0xA5, C=1, PARITY_EN=1 -> shiftreg `q` reproduces the sout sequence delayed by exactly 4 cycles.
